obstacle_spawner: RTL and testbench

//  Consumes the slow square wave from the spawn clock divider and turns each rising edge into a new

---
 rtl/obstacle_spawner_pkg.sv | 18 +
 rtl/spawn_lfsr.sv | 24 ++
 rtl/obstacle_spawner.sv | 127 ++++++++++++
 tb/tb_obstacle_spawner.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/obstacle_spawner_pkg.sv
// Shared constants for the obstacle spawner: track geometry, scroll rate and LFSR setup.
package obstacle_spawner_pkg;

  localparam int          NUM_SLOTS_DEF   = 8;
  localparam int          LANE_W_DEF      = 2;
  localparam int          NUM_LANES       = 2 ** LANE_W_DEF;
  localparam int          Y_W_DEF         = 10;
  localparam int          Y_MAX_DEF       = 480;
  localparam int          SCROLL_STEP_DEF = 4;
  localparam logic [15:0] LFSR_MASK       = 16'hB400;
  localparam logic [15:0] LFSR_SEED_DEF   = 16'hACE1;

  // Right-shifting Galois step: feedback taps are applied when the bit shifted out is 1.
  function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
    lfsr_step = {1'b0, cur[15:1]} ^ (cur[0] ? LFSR_MASK : 16'h0000);
  endfunction

endpackage

// File: rtl/spawn_lfsr.sv
// 16-bit Galois LFSR that supplies lane candidates; advances only while enabled.
module spawn_lfsr
  import obstacle_spawner_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SEED_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [15:0] q
);

  // LFSR state register
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= SEED;
    end else if (en) begin
      q <= lfsr_step(q);
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/obstacle_spawner.sv
// Obstacle slot table: spawns on rising edges of the spawn divider output, scrolls
// live obstacles down the track each frame and retires them past the bottom edge.
module obstacle_spawner
  import obstacle_spawner_pkg::*;
#(
  parameter int          NUM_SLOTS   = NUM_SLOTS_DEF,
  parameter int          LANE_W      = LANE_W_DEF,
  parameter int          Y_W         = Y_W_DEF,
  parameter int          Y_MAX       = Y_MAX_DEF,
  parameter int          SCROLL_STEP = SCROLL_STEP_DEF,
  parameter logic [15:0] LFSR_SEED   = LFSR_SEED_DEF,
  localparam int         IDX_W       = $clog2(NUM_SLOTS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_e,
  input  logic              spawn_clk,
  input  logic              scroll_tick,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_valid,
  output logic [LANE_W-1:0] rd_lane,
  output logic [Y_W-1:0]    rd_y,
  output logic [IDX_W:0]    active_count,
  output logic              spawn_pulse,
  output logic              retire_pulse,
  output logic              overflow
);

  logic [NUM_SLOTS-1:0] valid_r, valid_s;
  logic [LANE_W-1:0]    lane_r [NUM_SLOTS];
  logic [LANE_W-1:0]    lane_s [NUM_SLOTS];
  logic [Y_W-1:0]       y_r    [NUM_SLOTS];
  logic [Y_W-1:0]       y_s    [NUM_SLOTS];
  logic [Y_W:0]         ny_s;
  logic [LANE_W-1:0]    last_lane_r, cand_s, pick_s;
  logic [IDX_W-1:0]     free_idx_s;
  logic [IDX_W:0]       count_s;
  logic [15:0]          lfsr_q;
  logic                 spawn_prev_r, spawn_en_s, scroll_en_s, free_found_s, accept_s, any_retire_s;
  logic                 spawn_pulse_r, retire_pulse_r, overflow_r;
  logic                 lfsr_unused_s;

  spawn_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .en  (c_e),
    .q   (lfsr_q)
  );

  assign lfsr_unused_s = ^lfsr_q[15:LANE_W];
  assign spawn_en_s    = c_e & spawn_clk & ~spawn_prev_r;
  assign scroll_en_s   = c_e & scroll_tick;
  // Never repeat the previous lane: a colliding candidate is bumped to the next lane.
  assign cand_s        = lfsr_q[LANE_W-1:0];
  assign pick_s        = (cand_s == last_lane_r) ? cand_s + LANE_W'(1) : cand_s;
  assign accept_s      = spawn_en_s & free_found_s;

  // Lowest free slot, live-slot popcount and next-state of every slot
  always_comb begin
    free_found_s = 1'b0;
    free_idx_s   = {IDX_W{1'b0}};
    count_s      = {(IDX_W+1){1'b0}};
    any_retire_s = 1'b0;
    ny_s         = {(Y_W+1){1'b0}};
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      free_idx_s   = valid_r[i] ? free_idx_s : IDX_W'(i);
      free_found_s = free_found_s | ~valid_r[i];
      count_s      = count_s + (IDX_W+1)'(valid_r[i]);
    end
    for (int i = 0; i < NUM_SLOTS; i++) begin
      ny_s = {1'b0, y_r[i]} + (Y_W+1)'(SCROLL_STEP);
      // Only an invalid slot can be the spawn target, so spawn and scroll never collide.
      if (accept_s && (free_idx_s == IDX_W'(i))) begin
        valid_s[i] = 1'b1;
        lane_s[i]  = pick_s;
        y_s[i]     = {Y_W{1'b0}};
      end else if (scroll_en_s && valid_r[i] && (ny_s >= (Y_W+1)'(Y_MAX))) begin
        valid_s[i]   = 1'b0;
        lane_s[i]    = lane_r[i];
        y_s[i]       = {Y_W{1'b0}};
        any_retire_s = 1'b1;
      end else if (scroll_en_s && valid_r[i]) begin
        valid_s[i] = 1'b1;
        lane_s[i]  = lane_r[i];
        y_s[i]     = ny_s[Y_W-1:0];
      end else begin
        valid_s[i] = valid_r[i];
        lane_s[i]  = lane_r[i];
        y_s[i]     = y_r[i];
      end
    end
  end

  // Slot table, edge detector, lane history and status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r        <= {NUM_SLOTS{1'b0}};
      for (int i = 0; i < NUM_SLOTS; i++) begin
        lane_r[i] <= {LANE_W{1'b0}};
        y_r[i]    <= {Y_W{1'b0}};
      end
      last_lane_r    <= {LANE_W{1'b0}};
      spawn_prev_r   <= 1'b0;
      spawn_pulse_r  <= 1'b0;
      retire_pulse_r <= 1'b0;
      overflow_r     <= 1'b0;
    end else begin
      valid_r        <= valid_s;
      lane_r         <= lane_s;
      y_r            <= y_s;
      last_lane_r    <= accept_s ? pick_s : last_lane_r;
      spawn_prev_r   <= spawn_clk;
      spawn_pulse_r  <= accept_s;
      retire_pulse_r <= scroll_en_s & any_retire_s;
      overflow_r     <= overflow_r | (spawn_en_s & ~free_found_s);
    end
  end

  assign rd_valid     = valid_r[rd_idx];
  assign rd_lane      = rd_valid ? lane_r[rd_idx] : {LANE_W{1'b0}};
  assign rd_y         = rd_valid ? y_r[rd_idx] : {Y_W{1'b0}};
  assign active_count = count_s;
  assign spawn_pulse  = spawn_pulse_r;
  assign retire_pulse = retire_pulse_r;
  assign overflow     = overflow_r;

endmodule

// File: tb/tb_obstacle_spawner.sv
// Directed self-checking bench for obstacle_spawner: reset, spawn, retire, overflow,
// simultaneous spawn/retire, freeze and lane anti-repeat.
module tb_obstacle_spawner;

  logic       clk = 1'b0;
  logic       rst, c_e, spawn_clk, scroll_tick;
  logic [2:0] rd_idx;
  logic       rd_valid;
  logic [1:0] rd_lane;
  logic [9:0] rd_y;
  logic [3:0] active_count;
  logic       spawn_pulse, retire_pulse, overflow;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cnt;
  logic [15:0] m_lfsr;
  logic [15:0] saved_lfsr;
  logic [1:0]  exp_last, exp_lane, prev;
  logic [1:0]  exp_lanes [8];
  logic        found, wrapped;

  always #10 clk = ~clk;

  obstacle_spawner u_dut (
    .clk          (clk),
    .rst          (rst),
    .c_e          (c_e),
    .spawn_clk    (spawn_clk),
    .scroll_tick  (scroll_tick),
    .rd_idx       (rd_idx),
    .rd_valid     (rd_valid),
    .rd_lane      (rd_lane),
    .rd_y         (rd_y),
    .active_count (active_count),
    .spawn_pulse  (spawn_pulse),
    .retire_pulse (retire_pulse),
    .overflow     (overflow)
  );

  function automatic logic [15:0] ref_step(input logic [15:0] s);
    ref_step = s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  function automatic logic [1:0] ref_pick(input logic [15:0] s, input logic [1:0] last);
    logic [1:0] c;
    c = s[1:0];
    ref_pick = (c == last) ? c + 2'd1 : c;
  endfunction

  // Reference LFSR: value used by the DUT at the next edge
  always @(posedge clk) begin
    if (rst) m_lfsr <= 16'hACE1;
    else if (c_e) m_lfsr <= ref_step(m_lfsr);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("%s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic peek(input logic [2:0] idx);
    rd_idx = idx;
    #1;
  endtask

  task automatic spawn_edge;
    spawn_clk = 1'b0;
    tick;
    exp_lane  = ref_pick(m_lfsr, exp_last);
    spawn_clk = 1'b1;
    tick;
  endtask

  task automatic scroll_n(input int n);
    for (int k = 0; k < n; k++) begin
      scroll_tick = 1'b1;
      tick;
      scroll_tick = 1'b0;
      tick;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; c_e = 1'b0; spawn_clk = 1'b0; scroll_tick = 1'b0; rd_idx = 3'd0; exp_last = 2'd0;
    tick;
    tick;
    // Reset state
    peek(3'd0);
    check("rst_valid", 32'(rd_valid), 32'd0);
    check("rst_count", 32'(active_count), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_spawn_pulse", 32'(spawn_pulse), 32'd0);
    check("rst_retire_pulse", 32'(retire_pulse), 32'd0);
    check("rst_lfsr", 32'(u_dut.u_lfsr.q), 32'hACE1);
    rst = 1'b0; c_e = 1'b1;
    tick;
    check("lfsr_step1", 32'(u_dut.u_lfsr.q), 32'hE270);

    // Single spawn, then held-high spawn_clk must not respawn
    spawn_edge;
    peek(3'd0);
    check("spawn_pulse", 32'(spawn_pulse), 32'd1);
    check("spawn_count", 32'(active_count), 32'd1);
    check("spawn_valid0", 32'(rd_valid), 32'd1);
    check("spawn_y0", 32'(rd_y), 32'd0);
    check("spawn_lane0", 32'(rd_lane), 32'(exp_lane));
    exp_last = exp_lane;
    tick;
    check("spawn_pulse_1cyc", 32'(spawn_pulse), 32'd0);
    cnt = 0;
    for (int k = 0; k < 100; k++) begin
      tick;
      if (spawn_pulse) cnt++;
    end
    check("no_respawn_high", 32'(cnt), 32'd0);
    check("held_count", 32'(active_count), 32'd1);

    // Retire after 120 scroll ticks
    scroll_n(119);
    peek(3'd0);
    check("y_476", 32'(rd_y), 32'd476);
    check("valid_before_retire", 32'(rd_valid), 32'd1);
    check("no_early_retire", 32'(retire_pulse), 32'd0);
    scroll_tick = 1'b1;
    tick;
    scroll_tick = 1'b0;
    check("retired_valid", 32'(rd_valid), 32'd0);
    check("retire_pulse", 32'(retire_pulse), 32'd1);
    check("retired_count", 32'(active_count), 32'd0);
    check("retired_y", 32'(rd_y), 32'd0);
    check("retired_lane", 32'(rd_lane), 32'd0);
    tick;
    check("retire_pulse_1cyc", 32'(retire_pulse), 32'd0);

    // Overflow: eight accepted, ninth dropped
    for (int k = 0; k < 8; k++) begin
      spawn_edge;
      exp_lanes[k] = exp_lane;
      exp_last = exp_lane;
      check("fill_spawn_pulse", 32'(spawn_pulse), 32'd1);
    end
    check("full_no_overflow", 32'(overflow), 32'd0);
    check("full_count", 32'(active_count), 32'd8);
    spawn_edge;
    check("drop_no_pulse", 32'(spawn_pulse), 32'd0);
    check("drop_overflow", 32'(overflow), 32'd1);
    check("drop_count", 32'(active_count), 32'd8);
    for (int k = 0; k < 8; k++) begin
      peek(3'(k));
      check("fill_valid", 32'(rd_valid), 32'd1);
      check("fill_lane", 32'(rd_lane), 32'(exp_lanes[k]));
    end
    for (int k = 0; k < 5; k++) tick;
    check("overflow_sticky", 32'(overflow), 32'd1);
    rst = 1'b1; spawn_clk = 1'b0;
    tick;
    check("midrst_overflow", 32'(overflow), 32'd0);
    check("midrst_count", 32'(active_count), 32'd0);
    rst = 1'b0; exp_last = 2'd0;

    // Simultaneous retire of slot0 and spawn
    spawn_edge;
    exp_last = exp_lane;
    check("sim_first_spawn", 32'(spawn_pulse), 32'd1);
    scroll_n(119);
    peek(3'd0);
    check("sim_y_476", 32'(rd_y), 32'd476);
    spawn_clk = 1'b0;
    tick;
    exp_lane = ref_pick(m_lfsr, exp_last);
    spawn_clk = 1'b1; scroll_tick = 1'b1;
    tick;
    scroll_tick = 1'b0;
    check("sim_retire_pulse", 32'(retire_pulse), 32'd1);
    check("sim_spawn_pulse", 32'(spawn_pulse), 32'd1);
    check("sim_count", 32'(active_count), 32'd1);
    peek(3'd0);
    check("sim_slot0_free", 32'(rd_valid), 32'd0);
    peek(3'd1);
    check("sim_slot1_valid", 32'(rd_valid), 32'd1);
    check("sim_slot1_y", 32'(rd_y), 32'd0);
    check("sim_slot1_lane", 32'(rd_lane), 32'(exp_lane));
    exp_last = exp_lane;
    spawn_edge;
    exp_last = exp_lane;
    peek(3'd0);
    check("reuse_slot0_valid", 32'(rd_valid), 32'd1);
    check("reuse_slot0_y", 32'(rd_y), 32'd0);
    check("reuse_slot0_lane", 32'(rd_lane), 32'(exp_lane));
    check("reuse_count", 32'(active_count), 32'd2);

    // Freeze: edge and scroll while c_e=0 change nothing and are not replayed
    spawn_clk = 1'b0;
    tick;
    saved_lfsr = u_dut.u_lfsr.q;
    c_e = 1'b0; spawn_clk = 1'b1; scroll_tick = 1'b1;
    tick;
    check("frz_spawn_pulse", 32'(spawn_pulse), 32'd0);
    check("frz_retire_pulse", 32'(retire_pulse), 32'd0);
    check("frz_count", 32'(active_count), 32'd2);
    check("frz_lfsr", 32'(u_dut.u_lfsr.q), 32'(saved_lfsr));
    peek(3'd1);
    check("frz_y", 32'(rd_y), 32'd0);
    scroll_tick = 1'b0; c_e = 1'b1;
    tick;
    check("no_replay_pulse", 32'(spawn_pulse), 32'd0);
    check("no_replay_count", 32'(active_count), 32'd2);

    // Anti-repeat: spawn exactly when the candidate equals last_lane, until 3 wraps to 0
    wrapped = 1'b0;
    for (int r = 0; r < 4 && !wrapped; r++) begin
      spawn_clk = 1'b0;
      tick;
      found = 1'b0;
      for (int k = 0; k < 300 && !found; k++) begin
        if (m_lfsr[1:0] == exp_last) found = 1'b1;
        else tick;
      end
      check("collision_found", 32'(found), 32'd1);
      prev = exp_last;
      exp_lane = prev + 2'd1;
      spawn_clk = 1'b1;
      tick;
      check("collide_spawn_pulse", 32'(spawn_pulse), 32'd1);
      peek(3'(2 + r));
      check("collide_valid", 32'(rd_valid), 32'd1);
      check("collide_lane", 32'(rd_lane), 32'(exp_lane));
      if (prev == 2'd3) wrapped = 1'b1;
      exp_last = exp_lane;
    end
    check("wrap_seen", 32'(wrapped), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
